// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead slice per stage,
// registered group carry between stages, operand skew / sum deskew, valid/ready with global stall.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int unsigned NSTG = WIDTH / BLOCK;

    if (BLOCK == 0 || WIDTH == 0 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic advance;

    // Flat sum-of-products carries: every carry depends only on G/P and the slice carry-in.
    function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] g_in,
                                                 input logic [BLOCK-1:0] p_in,
                                                 input logic             ci);
        logic [BLOCK:0] cv;
        logic           t;
        cv    = '0;
        cv[0] = ci;
        for (int unsigned i = 1; i <= BLOCK; i++) begin
            t = ci;
            for (int unsigned m = 0; m < i; m++) t = t & p_in[m];
            cv[i] = t;
            for (int unsigned j = 0; j < i; j++) begin
                t = g_in[j];
                for (int unsigned m = j + 1; m < i; m++) t = t & p_in[m];
                cv[i] = cv[i] | t;
            end
        end
        return cv;
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int unsigned REM  = WIDTH - k * BLOCK;
        localparam int unsigned DONE = (k + 1) * BLOCK;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [BLOCK-1:0] gen;
        logic [BLOCK-1:0] prp;
        logic [BLOCK-1:0] s;
        logic [BLOCK:0]   c;
        logic [DONE-1:0]  sum_d;
        logic [DONE-1:0]  sum_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_src
            assign a_in  = in_a;
            assign b_in  = in_b ^ {WIDTH{in_sub}};
            assign c_in  = in_cin ^ in_sub;
            assign v_in  = in_valid;
            assign sum_d = s;
        end else begin : g_src
            assign a_in  = g_stg[k-1].g_fwd.a_q;
            assign b_in  = g_stg[k-1].g_fwd.b_q;
            assign c_in  = g_stg[k-1].c_q;
            assign v_in  = g_stg[k-1].v_q;
            assign sum_d = {s, g_stg[k-1].sum_q};
        end

        assign gen = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
        assign prp = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
        assign c   = lookahead(gen, prp, c_in);
        assign s   = prp ^ c[BLOCK-1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                c_q   <= c[BLOCK];
                sum_q <= sum_d;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            // Operand bits of slices not yet summed travel with the operation.
            logic [REM-BLOCK-1:0] a_q;
            logic [REM-BLOCK-1:0] b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[REM-1:BLOCK];
                    b_q <= b_in[REM-1:BLOCK];
                end
            end
        end else begin : g_last
            logic ovf_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= c[BLOCK] ^ c[BLOCK-1];
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].v_q;
    assign out_sum   = g_stg[NSTG-1].sum_q;
    assign out_cout  = g_stg[NSTG-1].c_q;
    assign out_ovf   = g_stg[NSTG-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed cases, streaming with back-pressure and reset on the default
// 16/4 adder, plus random sweeps on 8/8 and 32/4 instances against an arithmetic model.
module tb_pipelined_cla_adder;
    localparam int NOPS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_sw;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid, in_ready, in_cin, in_sub;
    logic [15:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf;

    pipelined_cla_adder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result packed as {ovf, cout, sum[w-1:0]} from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input int w, input longint unsigned a,
                                           input longint unsigned b, input bit cin, input bit sub);
        longint unsigned mask, sum;
        longint          sa, sb, sr, lim;
        bit              cout, ovf;
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(64'd1 << (w - 1));
        sa   = longint'(a);
        sb   = longint'(b);
        if (a[w-1]) sa = sa - 2 * lim;
        if (b[w-1]) sb = sb - 2 * lim;
        if (!sub) begin
            sum  = a + b + 64'(cin);
            cout = sum[w];
            sr   = sa + sb + longint'(cin);
        end else begin
            sum  = a - b - 64'(cin);
            cout = (a >= b + 64'(cin));
            sr   = sa - sb - longint'(cin);
        end
        ovf = (sr >= lim) || (sr < -lim);
        return (64'(ovf) << (w + 1)) | (64'(cout) << w) | (sum & mask);
    endfunction

    // Scoreboard for the default instance
    logic [63:0] q[$];
    int          cyc = 0, ofires = 0, ofirst = 0, olast = 0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else check("stream_res", 64'({out_ovf, out_cout, out_sum}), q.pop_front());
                if (ofires == 0) ofirst = cyc;
                olast = cyc;
                ofires++;
            end
            if (in_valid && in_ready) q.push_back(ref_op(16, 64'(in_a), 64'(in_b), in_cin, in_sub));
        end
    end

    task automatic new_op(input bit allow_sub);
        in_a   = 16'($urandom);
        in_b   = 16'($urandom);
        in_cin = 1'($urandom);
        in_sub = allow_sub ? 1'($urandom) : 1'b0;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        input logic [15:0] esum, input logic ecout, input logic eovf, input string tag);
        int lat;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 4);
        check({tag, "_res"}, 64'({out_ovf, out_cout, out_sum}), 64'({eovf, ecout, esum}));
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input bit allow_sub, input int stall_at, input int stall_len);
        int          sent = 0;
        int          c = 0;
        logic [63:0] snap = '0;
        bit          have = 1'b0;
        bit          fire;
        in_valid = 1'b1;
        new_op(allow_sub);
        while (sent < n && c < 500) begin
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            @(negedge clk);
            fire = in_ready;
            if (!out_ready && out_valid) begin
                check("stall_in_ready", 64'(in_ready), 0);
                if (have) check("stall_hold", 64'({out_ovf, out_cout, out_sum}), snap);
                else begin
                    snap = 64'({out_ovf, out_cout, out_sum});
                    have = 1'b1;
                end
            end
            @(posedge clk); #1;
            c++;
            if (fire) begin
                sent++;
                new_op(allow_sub);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 64'(sent), 64'(n));
    endtask

    // Random sweeps on other parameterisations, running alongside the directed tests
    bit sw_done[2];
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int unsigned W = (gi == 0) ? 8 : 32;
        localparam int unsigned B = (gi == 0) ? 8 : 4;
        logic         iv, ir, ovl, ordy, cin, sub, cout, ovf;
        logic [W-1:0] a, b, sum;
        logic [63:0]  sq[$];
        int           sent = 0;

        pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (
            .clk(clk), .rst(rst_sw),
            .in_valid(iv), .in_ready(ir),
            .in_a(a), .in_b(b), .in_cin(cin), .in_sub(sub),
            .out_valid(ovl), .out_ready(ordy),
            .out_sum(sum), .out_cout(cout), .out_ovf(ovf)
        );

        always @(negedge clk) begin
            if (!rst_sw) begin
                if (ovl && ordy) begin
                    if (sq.size() == 0) check("sweep_spurious", 1, 0);
                    else check("sweep_res", 64'({ovf, cout, sum}), sq.pop_front());
                end
                if (iv && ir) begin
                    sq.push_back(ref_op(int'(W), 64'(a), 64'(b), cin, sub));
                    sent++;
                end
            end
        end

        initial begin
            int c = 0;
            iv = 1'b0; ordy = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            wait (!rst_sw);
            @(posedge clk); #1;
            while (sent < NOPS && c < 60000) begin
                iv   = ($urandom_range(3) != 0);
                ordy = ($urandom_range(3) != 0);
                a    = W'($urandom);
                b    = W'($urandom);
                cin  = 1'($urandom);
                sub  = 1'($urandom);
                @(posedge clk); #1;
                c++;
            end
            iv = 1'b0; ordy = 1'b1; c = 0;
            while (sq.size() != 0 && c < 100) begin
                @(posedge clk); #1;
                c++;
            end
            check("sweep_sent", 64'(sent), 64'(NOPS));
            check("sweep_drain", 64'(sq.size()), 0);
            sw_done[gi] = 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; rst_sw = 1'b1;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b1; in_sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_sum", 64'(out_sum), 0);
        check("rst_cout_ovf", 64'({out_cout, out_ovf}), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        rst = 1'b0; rst_sw = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;

        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_chain");
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "signed_ovf");
        op16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
        op16(16'h1234, 16'h0234, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0, "sub_borrow");
        drain();

        ofires = 0;
        stream(8, 1'b0, -1, 0);
        drain();
        check("tput_count", 64'(ofires), 8);
        check("tput_span", 64'(olast - ofirst), 7);

        stream(24, 1'b1, 6, 5);
        drain();

        // Three operations in flight, then reset before any completes
        in_valid = 1'b1;
        repeat (3) begin
            new_op(1'b1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        new_op(1'b1);
        #1;
        check("midrst_valid", 64'(out_valid), 0);
        check("midrst_res", 64'({out_ovf, out_cout, out_sum}), 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_rst_idle", 64'(out_valid), 0);
        end
        op16(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, "after_rst");
        drain();

        // Result stalled at the output is cleared asynchronously by reset
        in_valid = 1'b1; in_a = 16'h8001; in_b = 16'h8000; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_res", 64'({out_ovf, out_cout, out_sum}), 64'({1'b1, 1'b1, 16'h0001}));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 0);
        check("async_rst_res", 64'({out_ovf, out_cout, out_sum}), 0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("after_async_idle", 64'(out_valid), 0);

        n = 0;
        while (!(sw_done[0] && sw_done[1]) && n < 90000) begin
            @(posedge clk);
            n++;
        end
        check("sweep_finished", 64'(sw_done[0] && sw_done[1]), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
